// File: rtl/comparator_seq.sv
// rtl/comparator_seq.sv - multi-cycle slice-serial magnitude comparator, MSB slice first, early exit
module comparator_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             e
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST_SLICE = CW'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CW-1:0]    slice_cnt;
  logic [WIDTH-1:0] sign_flip;
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;

  // Flipping both sign bits maps two's complement order onto unsigned order,
  // so the slice compare below never needs to know the mode.
  assign sign_flip = is_signed ? MSB_MASK : '0;
  assign slice_a   = op_a[WIDTH-1 -: DIGIT];
  assign slice_b   = op_b[WIDTH-1 -: DIGIT];

  // Control FSM: capture on start, walk slices from the top, stop on first difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      l         <= 1'b0;
      g         <= 1'b0;
      e         <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      slice_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= a ^ sign_flip;
            op_b      <= b ^ sign_flip;
            slice_cnt <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (slice_a < slice_b) begin
            l     <= 1'b1;
            g     <= 1'b0;
            e     <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (slice_a > slice_b) begin
            l     <= 1'b0;
            g     <= 1'b1;
            e     <= 1'b0;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (slice_cnt == LAST_SLICE) begin
            l     <= 1'b0;
            g     <= 1'b0;
            e     <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            op_a      <= op_a << DIGIT;
            op_b      <= op_b << DIGIT;
            slice_cnt <= slice_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
